redtin_dump_reader: RTL

//  Host-side reader for the Red Tin capture core. Arms on start, waits for capture done,

---
 rtl/redtin_pkg.sv | 36 +++
 rtl/redtin_byte_serializer.sv | 57 +++++
 rtl/redtin_dump_reader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/redtin_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : redtin_pkg
//  Brief    : Shared FSM encodings, sync byte default and width helpers for
//             the Red Tin dump reader.
//  Revision : 1.0  initial release
// ============================================================================
package redtin_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_HDR   = 3'd2,
        S_FETCH = 3'd3,
        S_LAT   = 3'd4,
        S_SEND  = 3'd5,
        S_REARM = 3'd6,
        S_DRAIN = 3'd7
    } state_t;

    localparam logic [7:0] c_SYNC_BYTE = 8'hA5;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // Counters need at least one bit even when only one value is possible.
    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/redtin_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : redtin_byte_serializer
//  Brief    : Loads a word and emits it MSB byte first on a valid/ready
//             stream; load_last selects how many bytes are sent.
//  Revision : 1.0  initial release
// ============================================================================
module redtin_byte_serializer
    import redtin_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int BCW        = cnt_width(DATA_WIDTH / 8)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [BCW-1:0]        load_last,
    input  logic                  stop,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  xfer,
    output logic                  last_byte_done
);

    logic [DATA_WIDTH-1:0] r_shreg;
    logic [BCW-1:0]        r_byte_cnt;
    logic [BCW-1:0]        r_last;
    logic                  r_valid;

    assign tx_data        = r_shreg[DATA_WIDTH-1 -: 8];
    assign tx_valid       = r_valid;
    assign xfer           = r_valid & tx_ready;
    assign last_byte_done = xfer & (r_byte_cnt == r_last);

    // stop lets the current byte finish, then holds valid low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg    <= '0;
            r_byte_cnt <= '0;
            r_last     <= '0;
            r_valid    <= 1'b0;
        end else if (load) begin
            r_shreg    <= load_data;
            r_byte_cnt <= '0;
            r_last     <= load_last;
            r_valid    <= 1'b1;
        end else if (xfer) begin
            r_shreg    <= r_shreg << 8;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (stop || (r_byte_cnt == r_last)) r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/redtin_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : redtin_dump_reader
//  Brief    : Arms on start, waits for capture done, streams a sync byte and
//             every capture word MSB first, then pulses la_reset.
//  Revision : 1.0  initial release
// ============================================================================
module redtin_dump_reader
    import redtin_pkg::*;
#(
    parameter int         DATA_WIDTH   = 128,
    parameter int         ADDR_WIDTH   = 9,
    parameter int         READ_LATENCY = 2,
    parameter logic [7:0] SYNC_BYTE    = c_SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    input  logic                  la_done,
    output logic [ADDR_WIDTH-1:0] la_read_addr,
    input  logic [DATA_WIDTH-1:0] la_read_data,
    output logic                  la_reset,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam int c_BYTES = DATA_WIDTH / 8;
    localparam int c_BCW   = cnt_width(c_BYTES);
    localparam int c_LCW   = cnt_width(READ_LATENCY + 1);
    localparam logic [c_BCW-1:0] c_LAST_BYTE = c_BCW'(c_BYTES - 1);

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_word;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_LCW-1:0]      r_lat;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [c_BCW-1:0]      w_load_last;
    logic                  w_stop;
    logic                  w_abort;
    logic                  w_xfer;
    logic                  w_last_done;

    // Asynchronous assert, synchronous release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign la_read_addr = r_addr;

    redtin_byte_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BCW        (c_BCW)
    ) u_ser (
        .clk            (clk),
        .rst_n          (w_rst_n),
        .load           (w_load),
        .load_data      (w_load_data),
        .load_last      (w_load_last),
        .stop           (w_stop),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .xfer           (w_xfer),
        .last_byte_done (w_last_done)
    );

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_load_data = '0;
        w_load_last = '0;
        w_stop      = 1'b0;
        w_abort     = !la_done && (r_state inside {S_HDR, S_FETCH, S_LAT, S_SEND});
        busy        = (r_state != S_IDLE);
        la_reset    = (r_state == S_REARM);
        case (r_state)
            S_IDLE:  if (start) w_next = S_WAIT;
            S_WAIT: begin
                if (la_done) begin
                    w_load      = 1'b1;
                    w_load_data = {SYNC_BYTE, {(DATA_WIDTH-8){1'b0}}};
                    w_next      = S_HDR;
                end
            end
            S_HDR, S_SEND: begin
                // A byte already on the wire is allowed to complete before IDLE
                if (w_abort) begin
                    w_stop = 1'b1;
                    w_next = (tx_valid && !tx_ready) ? S_DRAIN : S_IDLE;
                end else if (w_last_done) begin
                    if (r_state == S_HDR)   w_next = S_FETCH;
                    else if (&r_word)       w_next = S_REARM;
                    else                    w_next = S_FETCH;
                end
            end
            S_FETCH: w_next = w_abort ? S_IDLE : S_LAT;
            S_LAT: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (r_lat == '0) begin
                    w_load      = 1'b1;
                    w_load_data = la_read_data;
                    w_load_last = c_LAST_BYTE;
                    w_next      = S_SEND;
                end
            end
            S_REARM: w_next = S_IDLE;
            S_DRAIN: begin
                w_stop = 1'b1;
                if (!tx_valid || w_xfer) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_addr  <= '0;
            r_lat   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_HDR)
                r_word <= '0;
            else if (r_state == S_SEND && w_next == S_FETCH)
                r_word <= r_word + 1'b1;
            if (r_state == S_FETCH) begin
                r_addr <= r_word;
                r_lat  <= c_LCW'(READ_LATENCY);
            end else if (r_state == S_LAT && r_lat != '0) begin
                r_lat  <= r_lat - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
